// File: rtl/prog_loader.sv
// Boot-time program loader: byte stream in, 9-bit words out to instruction RAM.
// Holds the core idle until the XOR checksum of the image matches.
module prog_loader #(
    parameter int D = 8,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         im_we,
    output logic [D-1:0] im_addr,
    output logic [W-1:0] im_wdata,
    output logic         core_start,
    output logic         busy,
    output logic         err,
    output logic [D-1:0] count
);

    typedef enum logic [2:0] {
        IDLE, LEN, LO, HI, CSUM, DONE, ERR
    } state_t;

    state_t       state, state_nx;
    logic [7:0]   len;
    logic [7:0]   lo;
    logic [7:0]   csum;
    logic         xfer;
    logic         hi_ok;
    logic [D-1:0] count_inc;

    assign in_ready   = (state == LEN) || (state == LO) ||
                        (state == HI)  || (state == CSUM);
    assign busy       = in_ready;
    assign err        = (state == ERR);
    assign core_start = (state == DONE);
    assign xfer       = in_valid & in_ready;
    assign hi_ok      = (in_data[7:1] == 7'd0);
    assign count_inc  = count + 1'b1;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (load) state_nx = LEN;
            end
            LEN: begin
                if (xfer) state_nx = (in_data == 8'd0) ? ERR : LO;
            end
            LO: begin
                if (xfer) state_nx = HI;
            end
            HI: begin
                if (xfer) begin
                    if (!hi_ok)
                        state_nx = ERR;
                    else if (count_inc == D'(len))
                        state_nx = CSUM;
                    else
                        state_nx = LO;
                end
            end
            CSUM: begin
                if (xfer) state_nx = (in_data == csum) ? DONE : ERR;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset also drops a write queued by an HI byte taken on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            len      <= '0;
            lo       <= '0;
            csum     <= '0;
            count    <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else begin
            state <= state_nx;
            im_we <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (load) begin
                        count <= '0;
                        csum  <= '0;
                    end
                end
                LEN: begin
                    if (xfer) len <= in_data;
                end
                LO: begin
                    if (xfer) begin
                        lo   <= in_data;
                        csum <= csum ^ in_data;
                    end
                end
                HI: begin
                    if (xfer) begin
                        csum <= csum ^ in_data;
                        if (hi_ok) begin
                            im_we    <= 1'b1;
                            im_addr  <= count;
                            im_wdata <= W'({in_data[0], lo});
                            count    <= count_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued by stimulus,
// popped and compared by an independent write monitor.
module tb_prog_loader;

    localparam int D = 8;
    localparam int W = 9;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         im_we;
    logic [D-1:0] im_addr;
    logic [W-1:0] im_wdata;
    logic         core_start;
    logic         busy;
    logic         err;
    logic [D-1:0] count;

    int total = 0;
    int bad = 0;
    int acc = 0;
    logic [D+W-1:0] exp_q[$];

    prog_loader #(.D(D), .W(W)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .im_we(im_we),
        .im_addr(im_addr),
        .im_wdata(im_wdata),
        .core_start(core_start),
        .busy(busy),
        .err(err),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk)
        if (!reset && in_valid && in_ready) acc <= acc + 1;

    // Write monitor: every im_we pulse must match the head of the queue.
    always @(negedge clk) begin
        if (im_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {15'd0, im_addr, im_wdata}, 0);
            end else begin
                logic [D+W-1:0] e;
                e = exp_q.pop_front();
                check("wr_addr", im_addr, e[D+W-1:W]);
                check("wr_data", im_wdata, e[W-1:0]);
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit gap);
        int n;
        int g;
        n = 0;
        g = 0;
        @(negedge clk);
        if (gap) begin
            while ($urandom_range(1, 0) == 1 && g < 8) begin
                in_valid = 1'b0;
                g++;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 1, 0);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_load();
        @(negedge clk);
        in_valid = 1'b0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic push(input logic [D-1:0] a, input logic [W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic good_image(input bit gap);
        send(8'h03, gap);
        send(8'hA5, gap);
        send(8'h01, gap);
        push(8'd0, 9'h1A5);
        send(8'hFF, gap);
        send(8'h00, gap);
        push(8'd1, 9'h0FF);
        send(8'h00, gap);
        send(8'h01, gap);
        push(8'd2, 9'h100);
        send(8'h5A, gap);
        idle();
    endtask

    task automatic check_done(input string tag);
        check({tag, "_start"}, core_start, 1);
        check({tag, "_count"}, count, 3);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_addr"}, im_addr, 2);
        check({tag, "_wdata"}, im_wdata, 9'h100);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_we"}, im_we, 0);
        check({tag, "_addr"}, im_addr, 0);
        check({tag, "_wdata"}, im_wdata, 0);
        check({tag, "_start"}, core_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_count"}, count, 0);
    endtask

    initial begin
        int a0;
        reset    = 1'b1;
        load     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset("rst");

        // good image, continuous valid
        do_load();
        check("load_busy", busy, 1);
        check("load_ready", in_ready, 1);
        good_image(1'b0);
        check_done("t1");

        // bad checksum
        do_load();
        send(8'h03, 1'b0);
        send(8'hA5, 1'b0);
        send(8'h01, 1'b0);
        push(8'd0, 9'h1A5);
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        push(8'd1, 9'h0FF);
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        push(8'd2, 9'h100);
        send(8'h5B, 1'b0);
        idle();
        check("csum_err", err, 1);
        check("csum_start", core_start, 0);
        check("csum_ready", in_ready, 0);
        do_load();
        check("reload_err", err, 0);
        check("reload_busy", busy, 1);
        check("reload_count", count, 0);

        // len=2, bad second HI byte
        send(8'h02, 1'b0);
        send(8'h11, 1'b0);
        send(8'h01, 1'b0);
        push(8'd0, 9'h111);
        send(8'h22, 1'b0);
        send(8'h03, 1'b0);
        idle();
        @(negedge clk);
        check("hi_err", err, 1);
        check("hi_count", count, 1);
        check("hi_start", core_start, 0);

        // zero length
        do_load();
        send(8'h00, 1'b0);
        idle();
        check("len0_err", err, 1);
        check("len0_count", count, 0);
        check("len0_ready", in_ready, 0);

        // good image with random valid gaps
        a0 = acc;
        do_load();
        good_image(1'b1);
        check_done("t5");
        check("t5_bytes", acc - a0, 8);

        // reset coincident with the second HI transfer
        do_load();
        send(8'h03, 1'b0);
        send(8'hA5, 1'b0);
        send(8'h01, 1'b0);
        push(8'd0, 9'h1A5);
        send(8'hFF, 1'b0);
        send(8'h00, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        check_reset("mid");
        @(negedge clk);
        check("mid_we_next", im_we, 0);
        do_load();
        good_image(1'b0);
        check_done("t6");

        repeat (2) @(negedge clk);
        check("q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
